// File: rtl/bcd_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan_if
// Description : Producer-to-display handshake bundle carrying a 3-digit BCD
//               value (hundreds/tens/ones) with a valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_seg_scan_if;
  logic [11:0] bcd_in;     // [11:8] hundreds, [7:4] tens, [3:0] ones
  logic        bcd_valid;  // bcd_in is valid this cycle
  logic        bcd_ready;  // consumer pending slot is empty

  // Producer side
  modport master (
    output bcd_in,
    output bcd_valid,
    input  bcd_ready
  );

  // Display side
  modport slave (
    input  bcd_in,
    input  bcd_valid,
    output bcd_ready
  );
endinterface
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan
// Description : 3-digit common-anode multiplexed seven-segment driver.
//               Accepts BCD values into a one-entry pending buffer and swaps
//               them into the display only at frame boundaries, so a digit
//               never tears mid-frame. Performs leading-zero blanking and
//               flags digits above 9 (shown as 'E').
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_scan #(
  parameter int PRESCALE = 4,  // clk cycles each digit is lit per slot (>= 1)
  parameter int CNT_W    = 3   // slot counter width, must hold PRESCALE-1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bcd_seg_scan_if.slave   bus,
  output logic [6:0]      seg_n,
  output logic [2:0]      an_n,
  output logic            err
);

  // Scan order D0 -> G0 -> D1 -> G1 -> D2 -> G2; Gx are one-cycle blank gaps
  // that keep the previous digit from ghosting into the next anode.
  typedef enum logic [2:0] {
    S_D0 = 3'd0,
    S_G0 = 3'd1,
    S_D1 = 3'd2,
    S_G1 = 3'd3,
    S_D2 = 3'd4,
    S_G2 = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [2:0]       AN_OFF   = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [11:0]      pend_q;
  logic             pend_full_q;
  logic [11:0]      disp_q;
  logic             err_q;

  logic             accept;
  logic             xfer;
  logic             cnt_done;
  logic             hund_zero;
  logic             tens_zero;

  // Active-low segment pattern (bit0=a .. bit6=g); anything above 9 shows 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h06;
    endcase
    return seg;
  endfunction

  function automatic logic nib_bad(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

  // The buffer can only be full or filling, never both: ready is low whenever
  // a boundary transfer could happen, so accept and xfer are exclusive.
  assign bus.bcd_ready = !pend_full_q;
  assign accept        = bus.bcd_valid && !pend_full_q;
  assign xfer          = (state_q == S_G2) && pend_full_q;
  assign cnt_done      = (cnt_q == CNT_LAST);
  assign err           = err_q;

  // State and slot counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_G2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: digit slots hold for PRESCALE cycles, gaps for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_D0: if (cnt_done) state_d = S_G0; else cnt_d = cnt_q + 1'b1;
      S_G0: state_d = S_D1;
      S_D1: if (cnt_done) state_d = S_G1; else cnt_d = cnt_q + 1'b1;
      S_G1: state_d = S_D2;
      S_D2: if (cnt_done) state_d = S_G2; else cnt_d = cnt_q + 1'b1;
      S_G2: state_d = S_D0;
      default: state_d = S_G2;
    endcase
  end

  // Pending buffer fill and frame-boundary swap into the displayed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= '0;
      err_q       <= 1'b0;
    end else if (xfer) begin
      disp_q      <= pend_q;
      pend_full_q <= 1'b0;
      err_q       <= nib_bad(pend_q[11:8]) || nib_bad(pend_q[7:4]) ||
                     nib_bad(pend_q[3:0]);
    end else if (accept) begin
      pend_q      <= bus.bcd_in;
      pend_full_q <= 1'b1;
    end
  end

  // Blanking looks at the raw nibble value, so 'E' digits are never blanked.
  assign hund_zero = (disp_q[11:8] == 4'd0);
  assign tens_zero = (disp_q[7:4]  == 4'd0);

  // Anode/segment drive straight from state and display register.
  always_comb begin
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    case (state_q)
      S_D0: begin
        an_n  = 3'b110;
        seg_n = seg_decode(disp_q[3:0]);
      end
      S_D1: begin
        if (!(hund_zero && tens_zero)) begin
          an_n  = 3'b101;
          seg_n = seg_decode(disp_q[7:4]);
        end
      end
      S_D2: begin
        if (!hund_zero) begin
          an_n  = 3'b011;
          seg_n = seg_decode(disp_q[11:8]);
        end
      end
      default: begin
        an_n  = AN_OFF;
        seg_n = SEG_OFF;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the 12-bit binary-to-BCD converter output (hundreds/tens/ones nibbles).
- Drives a 3-digit, common-anode, time-multiplexed seven-segment display with leading-zero blanking and invalid-digit flagging.
- A one-entry pending buffer with a valid/ready handshake means new values take effect only at frame boundaries, so no digit tears mid-frame.

Parameters:
PRESCALE, 4, number of clk cycles each digit is lit per slot (min 1)
CNT_W, 3, width of slot counter; must hold PRESCALE-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
bcd_in  input  12  [11:8] hundreds, [7:4] tens, [3:0] ones
bcd_valid  input  1  bcd_in valid this cycle
bcd_ready  output  1  pending buffer empty; transfer occurs when bcd_valid && bcd_ready
seg_n  output  7  active-low segments, bit0=a … bit6=g
an_n  output  3  active-low anodes, bit0=ones, bit1=tens, bit2=hundreds
err  output  1  currently displayed value contains a nibble > 9

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Registers:
  - state (6 states)
  - cnt[CNT_W-1:0]
  - pend[11:0] with pend_full
  - disp[11:0]
  - err
- Reset values: state=G2, cnt=0, pend_full=0, disp=0, err=0, so an_n=3'b111 and seg_n=7'h7F.
- bcd_ready = !pend_full, combinational from the flop.
- Reset asserted mid-frame discards pend and disp immediately.
- FSM sequence is D0 -> G0 -> D1 -> G1 -> D2 -> G2 -> D0.
  - Dx states last PRESCALE cycles; cnt counts 0..PRESCALE-1 and clears on exit.
  - Gx (ghost-guard gap) states last exactly 1 cycle.
  - Frame length = 3*(PRESCALE+1) cycles.
- Frame boundary is the G2 cycle. On the G2 clock edge, if pend_full: disp<=pend, pend_full<=0, err<=(any nibble of pend > 9).
- Handshake:
  - On accept, pend<=bcd_in and pend_full<=1.
  - Accept in the same cycle as a G2 transfer is impossible (ready=0 when full).
  - Accept during G2 with pend empty lands in pend and is displayed at the next boundary.
  - bcd_in is ignored when ready=0; the producer must hold valid and data.
- Outputs are combinational from state/disp (no extra latency):
  - Gx: an_n=111, seg_n=7F.
  - Dk: nibble k of disp is decoded; an_n has bit k low.
- Leading-zero blanking:
  - Hundreds blanked if disp[11:8]==0.
  - Tens blanked if disp[11:8]==0 and disp[7:4]==0.
  - Ones never blanked.
  - A blanked slot still occupies its PRESCALE cycles but drives an_n=111, seg_n=7F.
- Decode (seg_n hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - 10..15 display 'E'=06
  - A nibble of 0 in a higher position is blanking-tested on its value only; 'E' is never blanked.
- Width rules: no arithmetic beyond cnt increment and 4-bit compares; cnt must not wrap past PRESCALE-1.

Test Plan:
1. Reset: hold rst, release -> an_n=111, seg_n=7F, bcd_ready=1, err=0; first cycle after release is G2, next cycle D0 shows an_n=110, seg_n=40; D1/D2 slots show an_n=111.
2. Load bcd_in=12'h255 pulse with PRESCALE=4 -> bcd_ready=0 from next cycle until the G2 edge, ready=1 one cycle after; next frame shows D0 seg_n=12 an_n=110, D1 seg_n=12 an_n=101, D2 seg_n=24 an_n=011, each 4 cycles with 1-cycle gaps.
3. Back-pressure: assert valid with 12'h123 then hold valid with 12'h456 -> second held with ready=0 for the remainder of the frame; 123 displayed for one full frame, then 456; no value lost or duplicated.
4. Leading zeros: 12'h007 -> D0 seg_n=78, D1/D2 an_n=111; 12'h100 -> digits 1,0,0 all lit (seg_n 79/40/40) since middle zero is not leading.
5. Invalid digit: 12'h0A3 -> after boundary err=1, D1 seg_n=06, D2 blanked; then load 12'h000 -> err=0 after next boundary, only D0 lit with seg_n=40.
6. Reset mid-frame: pend_full=1 and state=D1, assert rst asynchronously (not on an edge) -> outputs go to reset values immediately, pend dropped, bcd_ready=1, display shows 0 after release.
